// File: rtl/tx_byte_buffer_pkg.sv
// Shared definitions for the transmit byte buffer: default geometry and
// the pacing FSM state encoding.
package tx_byte_buffer_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;
    localparam int unsigned DEFAULT_AW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_byte_buffer_fifo.sv
// Power-of-two byte FIFO with occupancy count. Pushes while full and pops
// while empty are ignored, so pointers wrap silently modulo DEPTH.
module byte_fifo
    import tx_byte_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = DEFAULT_AW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [7:0]    push_data_i,
    input  logic          pop_i,
    output logic [7:0]    pop_data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push is refused when full even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/tx_byte_buffer.sv
// Buffers Sobel result bytes and paces them out to a UART transmitter,
// issuing one start strobe per byte and waiting for the transmit to finish.
module tx_byte_buffer
    import tx_byte_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          tx_active,
    input  logic          tx_done,
    output logic [7:0]    out_data,
    output logic          out_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);

    tx_state_e   state_q, state_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  head_data;
    logic        pop;

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (in_valid),
        .push_data_i (in_data),
        .pop_i       (pop),
        .pop_data_o  (head_data),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (!empty)   state_d = ST_ISSUE;
            ST_ISSUE:                    state_d = ST_WAIT_START;
            ST_WAIT_START: if (tx_active) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE:  if (tx_done)  state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_ISSUE);
        pop       = (state_q == ST_IDLE) && !empty;
    end

    // The head byte is captured on the pop so it stays put for the whole transfer.
    always_comb begin
        out_data_d = pop ? head_data : out_data_q;
        overflow_d = overflow_q | (in_valid & full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_data = out_data_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_tx_byte_buffer.sv
// Directed self-checking bench for tx_byte_buffer with a simple UART
// transmitter model and an output-order monitor.
module tb_tx_byte_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [7:0]    in_data  = '0;
    logic          in_valid = 1'b0;
    logic          d_active = 1'b0;
    logic          d_done   = 1'b0;
    logic          m_active = 1'b0;
    logic          m_done   = 1'b0;
    logic          tx_active, tx_done;
    logic [7:0]    out_data;
    logic          out_valid, empty, full, overflow;
    logic [AW:0]   count;

    logic          tx_auto = 1'b0;
    logic          tx_rand = 1'b0;
    logic [7:0]    got_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            last_done_cyc  = -100;
    int            last_valid_cyc = -100;

    assign tx_active = d_active | m_active;
    assign tx_done   = d_done | m_done;

    tx_byte_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Drives the transmitter handshake from WAIT_START back to IDLE.
    task automatic finish_tx();
        d_active = 1'b1;
        step();
        d_active = 1'b0;
        d_done   = 1'b1;
        step();
        d_done   = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget, input string tag);
        int i = 0;
        while (got_q.size() < n && i < budget) begin
            step();
            i++;
        end
        check(tag, got_q.size() >= n, 1);
    endtask

    // Output monitor: single-cycle strobes, an IDLE cycle after each tx_done.
    always @(negedge clk) begin
        if (tx_done) last_done_cyc = cyc;
        if (out_valid) begin
            check("ov_single_cycle", (cyc - last_valid_cyc) > 1, 1);
            check("ov_idle_gap", (cyc - last_done_cyc) >= 2, 1);
            got_q.push_back(out_data);
            last_valid_cyc = cyc;
        end
    end

    // Transmitter model: busy some cycles after the strobe, then done pulse.
    initial begin
        int d1;
        int d2;
        forever begin
            @(posedge clk);
            #1;
            if (tx_auto && out_valid) begin
                d1 = tx_rand ? int'($urandom_range(4, 1)) : 2;
                d2 = tx_rand ? int'($urandom_range(8, 1)) : 20;
                repeat (d1) begin @(posedge clk); #1; end
                m_active = 1'b1;
                repeat (d2) begin @(posedge clk); #1; end
                m_active = 1'b0;
                m_done   = 1'b1;
                @(posedge clk);
                #1;
                m_done   = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b0;
        step();
        step();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        reset = 1'b1;

        // Single byte latency
        while (cyc < 10) step();
        check("t1_count0", count, 0);
        check("t1_idle", out_valid, 0);
        push(8'hA5);
        check("t1_count1", count, 1);
        check("t1_no_valid_n1", out_valid, 0);
        step();
        check("t1_valid_n2", out_valid, 1);
        check("t1_data", out_data, 8'hA5);
        check("t1_count_back0", count, 0);
        step();
        check("t1_valid_dropped", out_valid, 0);

        // tx_done in WAIT_START is ignored
        push(8'h5C);
        d_done = 1'b1;
        step();
        d_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t1b_done_ignored", out_valid, 0);
            check("t1b_count_held", count, 1);
            check("t1b_data_stable", out_data, 8'hA5);
            step();
        end
        finish_tx();
        check("t1b_idle_gap", out_valid, 0);
        check("t1b_data_still", out_data, 8'hA5);
        step();
        check("t1b_valid", out_valid, 1);
        check("t1b_data", out_data, 8'h5C);
        check("t1b_count", count, 0);
        step();
        finish_tx();

        // Three back-to-back bytes through the transmitter model
        got_q.delete();
        tx_auto = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_got(3, 200, "t2_timeout");
        repeat (40) step();
        check("t2_n_bytes", got_q.size(), 3);
        check("t2_b0", got_q[0], 8'h11);
        check("t2_b1", got_q[1], 8'h22);
        check("t2_b2", got_q[2], 8'h33);
        check("t2_empty", empty, 1);

        // Fill to full with the transmitter held busy, then drain
        tx_auto = 1'b0;
        push(8'hEE);
        repeat (3) step();
        d_active = 1'b1;
        step();
        for (int i = 0; i < 15; i++) push(8'(i));
        check("t3_count15", count, 15);
        check("t3_not_full15", full, 0);
        push(8'h0F);
        check("t3_full16", full, 1);
        check("t3_count16", count, 16);
        check("t3_no_ovf_yet", overflow, 0);
        push(8'h10);
        check("t3_ovf", overflow, 1);
        check("t3_count_dropped", count, 16);
        got_q.delete();
        tx_auto  = 1'b1;
        d_active = 1'b0;
        d_done   = 1'b1;
        step();
        d_done   = 1'b0;
        wait_got(16, 800, "t3_timeout");
        repeat (40) step();
        check("t3_n_bytes", got_q.size(), 16);
        for (int i = 0; i < 16; i++) check("t3_order", got_q[i], i);
        check("t3_ovf_sticky", overflow, 1);
        check("t3_empty", empty, 1);

        tx_auto = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("rst2_ovf_cleared", overflow, 0);
        reset = 1'b1;
        step();

        // Simultaneous push and pop with count=5
        push(8'h77);
        repeat (3) step();
        d_active = 1'b1;
        step();
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        check("t4a_count5", count, 5);
        d_active = 1'b0;
        d_done   = 1'b1;
        step();
        d_done   = 1'b0;
        check("t4a_idle", out_valid, 0);
        in_data  = 8'h99;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t4a_count_same", count, 5);
        check("t4a_valid", out_valid, 1);
        check("t4a_data", out_data, 8'h40);

        // Full buffer, push during the pop cycle is dropped
        step();
        d_active = 1'b1;
        step();
        for (int i = 0; i < 11; i++) push(8'hB0 + 8'(i));
        check("t4b_full", full, 1);
        d_active = 1'b0;
        d_done   = 1'b1;
        step();
        d_done   = 1'b0;
        check("t4b_full_idle", full, 1);
        check("t4b_ovf_before", overflow, 0);
        in_data  = 8'hDD;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t4b_count15", count, 15);
        check("t4b_ovf", overflow, 1);
        check("t4b_valid", out_valid, 1);
        check("t4b_data", out_data, 8'h41);

        // Asynchronous reset in WAIT_DONE with four bytes stored
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        push(8'h3C);
        repeat (3) step();
        d_active = 1'b1;
        step();
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        check("t5_count4", count, 4);
        check("t5_data", out_data, 8'h3C);
        #2 reset = 1'b0;
        #1;
        check("t5_async_count", count, 0);
        check("t5_async_empty", empty, 1);
        check("t5_async_full", full, 0);
        check("t5_async_ovf", overflow, 0);
        check("t5_async_valid", out_valid, 0);
        check("t5_async_data", out_data, 8'h00);
        d_active = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        d_done = 1'b1;
        step();
        d_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t5_stray_done", out_valid, 0);
            check("t5_still_empty", empty, 1);
            step();
        end

        // 40-byte stream with random transmitter timing
        got_q.delete();
        tx_auto = 1'b1;
        tx_rand = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 10; k++) push(8'(b * 10 + k));
            repeat (160) step();
        end
        wait_got(40, 400, "t6_timeout");
        repeat (30) step();
        check("t6_n_bytes", got_q.size(), 40);
        for (int i = 0; i < 40; i++) check("t6_order", got_q[i], i);
        check("t6_no_ovf", overflow, 0);
        check("t6_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
